// File: rtl/spi_xfer_ctrl.sv
// Byte-wide SPI mode-0 master: shifts one byte MSB-first per START strobe.
// Define SPI_CLKDIV_EN to add the DIV port and a programmable SCK half-period.
module spi_xfer_ctrl #(
  parameter int DIVW = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            START,
  input  logic [7:0]      TXD,
  input  logic            SETSS,
  input  logic [1:0]      SSV,
`ifdef SPI_CLKDIV_EN
  input  logic [DIVW-1:0] DIV,
`endif
  input  logic [2:0]      MISO,
  output logic            SCK,
  output logic            MOSI,
  output logic [1:0]      nSS,
  output logic [7:0]      RXD,
  output logic            BUSY,
  output logic            DONE
);

  // state | meaning
  // IDLE  | waiting for START; SETSS accepted here only
  // LOW   | SCK low phase of the current bit
  // HIGH  | SCK high phase; MISO was sampled on entry
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t     state, state_nxt;
  logic [6:0] tx, tx_nxt;
  logic [7:0] rx, rx_nxt, rxd_nxt;
  logic [2:0] bcnt, bcnt_nxt;
  logic [1:0] nss_nxt;
  logic       sck_nxt, mosi_nxt, busy_nxt, done_nxt;
  logic       misox, phase_end;

  assign misox = (MISO[0] & ~nSS[0]) | (MISO[1] & ~nSS[1]) | (MISO[2] & nSS[0] & nSS[1]);

`ifdef SPI_CLKDIV_EN
  logic [DIVW-1:0] d_lat, d_lat_nxt, dcnt, dcnt_nxt;

  assign phase_end = (dcnt == '0);

  always_comb begin
    d_lat_nxt = d_lat;
    dcnt_nxt  = dcnt;
    if (state == IDLE) begin
      if (START) begin
        d_lat_nxt = DIV;
        dcnt_nxt  = DIV;
      end
    end else if (dcnt == '0) begin
      dcnt_nxt = d_lat;
    end else begin
      dcnt_nxt = dcnt - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      d_lat <= '0;
      dcnt  <= '0;
    end else begin
      d_lat <= d_lat_nxt;
      dcnt  <= dcnt_nxt;
    end
  end
`else
  // Without the divider every phase is a single CLK cycle.
  localparam logic [DIVW-1:0] D_FIXED = '0;
  assign phase_end = (D_FIXED == '0);
`endif

  always_comb begin
    state_nxt = state;
    tx_nxt    = tx;
    rx_nxt    = rx;
    rxd_nxt   = RXD;
    bcnt_nxt  = bcnt;
    sck_nxt   = SCK;
    mosi_nxt  = MOSI;
    nss_nxt   = nSS;
    busy_nxt  = BUSY;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (SETSS) nss_nxt = SSV;
        if (START) begin
          tx_nxt    = TXD[6:0];
          mosi_nxt  = TXD[7];
          bcnt_nxt  = 3'd7;
          sck_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (phase_end) begin
          sck_nxt   = 1'b1;
          rx_nxt    = {rx[6:0], misox};
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sck_nxt = 1'b0;
          if (bcnt == 3'd0) begin
            rxd_nxt   = rx;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            bcnt_nxt  = bcnt - 1'b1;
            mosi_nxt  = tx[6];
            tx_nxt    = {tx[5:0], 1'b0};
            state_nxt = LOW;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      tx    <= '0;
      rx    <= '0;
      RXD   <= '0;
      bcnt  <= '0;
      SCK   <= 1'b0;
      MOSI  <= 1'b0;
      nSS   <= 2'b11;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      tx    <= tx_nxt;
      rx    <= rx_nxt;
      RXD   <= rxd_nxt;
      bcnt  <= bcnt_nxt;
      SCK   <= sck_nxt;
      MOSI  <= mosi_nxt;
      nSS   <= nss_nxt;
      BUSY  <= busy_nxt;
      DONE  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: vector table of whole-byte transfers plus
// hand sequences for busy protection, back-to-back bytes and reset abort.
module tb_spi_xfer_ctrl;
  localparam int DIVW = 4;

  logic       CLK = 1'b0;
  logic       nRST, START, SETSS, loop_en;
  logic [7:0] TXD;
  logic [1:0] SSV;
  logic [2:0] miso_drv, MISO;
  logic       SCK, MOSI, BUSY, DONE;
  logic [1:0] nSS;
  logic [7:0] RXD;
`ifdef SPI_CLKDIV_EN
  logic [DIVW-1:0] DIV;
`endif

  int dval = 0;
  int checks = 0;
  int errors = 0;

  assign MISO = loop_en ? {miso_drv[2:1], MOSI} : miso_drv;

  always #5 CLK = ~CLK;

  spi_xfer_ctrl #(.DIVW(DIVW)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .TXD(TXD), .SETSS(SETSS), .SSV(SSV),
`ifdef SPI_CLKDIV_EN
    .DIV(DIV),
`endif
    .MISO(MISO), .SCK(SCK), .MOSI(MOSI), .nSS(nSS), .RXD(RXD), .BUSY(BUSY), .DONE(DONE)
  );

  typedef struct {
    logic [7:0] txd;
    logic [1:0] ssv;
    logic       lp;
    logic [2:0] mi;
    logic [7:0] exp_rxd;
  } vec_t;

  vec_t vecs [0:6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic [7:0] txd, input logic [1:0] ssv,
                      input logic lp, input logic [2:0] mi, input logic [7:0] exp_rxd);
    logic [7:0] bits;
    int rises, highs, n;
    logic prev;
    loop_en  = lp;
    miso_drv = mi;
`ifdef SPI_CLKDIV_EN
    DIV = DIVW'(dval);
`endif
    START = 1'b1; TXD = txd; SETSS = 1'b1; SSV = ssv;
    tick();
    START = 1'b0; SETSS = 1'b0; TXD = 8'h00;
`ifdef SPI_CLKDIV_EN
    DIV = '1;  // latched divider must ignore this
`endif
    check({tag, " busy_at_e0"}, 32'(BUSY), 32'd1);
    check({tag, " mosi_at_e0"}, 32'(MOSI), 32'(txd[7]));
    check({tag, " nss"}, 32'(nSS), 32'(ssv));
    bits = 8'h00; rises = 0; highs = 0; n = 0; prev = SCK;
    while (n < 20 * (dval + 1)) begin
      tick();
      n++;
      if (SCK) highs++;
      if (SCK && !prev) begin
        bits = {bits[6:0], MOSI};
        rises++;
      end
      prev = SCK;
      if (DONE) break;
    end
    check({tag, " done_latency"}, 32'(n), 32'(16 * (dval + 1)));
    check({tag, " sck_rises"}, 32'(rises), 32'd8);
    check({tag, " sck_high_cycles"}, 32'(highs), 32'(8 * (dval + 1)));
    check({tag, " mosi_bits"}, 32'(bits), 32'(txd));
    check({tag, " rxd"}, 32'(RXD), 32'(exp_rxd));
    check({tag, " busy_at_done"}, 32'(BUSY), 32'd0);
    tick();
    check({tag, " done_cleared"}, 32'(DONE), 32'd0);
    check({tag, " mosi_hold"}, 32'(MOSI), 32'(txd[0]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] bits;
    logic prev;
    int done_cnt, first_done, rises;

    vecs[0] = '{8'hA5, 2'b10, 1'b1, 3'b000, 8'hA5};
    vecs[1] = '{8'h3C, 2'b01, 1'b0, 3'b010, 8'hFF};
    vecs[2] = '{8'hFF, 2'b11, 1'b0, 3'b011, 8'h00};
    vecs[3] = '{8'h00, 2'b11, 1'b0, 3'b100, 8'hFF};
    vecs[4] = '{8'h81, 2'b10, 1'b0, 3'b110, 8'h00};
    vecs[5] = '{8'h5A, 2'b10, 1'b1, 3'b000, 8'h5A};
    vecs[6] = '{8'h0F, 2'b00, 1'b0, 3'b001, 8'hFF};

    nRST = 1'b0; START = 1'b0; SETSS = 1'b0; TXD = 8'h00; SSV = 2'b11;
    loop_en = 1'b0; miso_drv = 3'b000;
`ifdef SPI_CLKDIV_EN
    DIV = '0;
`endif
    tick();
    tick();
    nRST = 1'b1;
    check("reset sck", 32'(SCK), 32'd0);
    check("reset mosi", 32'(MOSI), 32'd0);
    check("reset nss", 32'(nSS), 32'd3);
    check("reset busy", 32'(BUSY), 32'd0);
    check("reset done", 32'(DONE), 32'd0);
    check("reset rxd", 32'(RXD), 32'd0);

    for (int i = 0; i < 7; i++)
      xfer($sformatf("vec%0d", i), vecs[i].txd, vecs[i].ssv, vecs[i].lp, vecs[i].mi, vecs[i].exp_rxd);

    // Busy protection: second START/SETSS land mid-byte and must be dropped.
    loop_en = 1'b1; miso_drv = 3'b000;
    START = 1'b1; TXD = 8'h11; SETSS = 1'b1; SSV = 2'b10;
    tick();
    START = 1'b0; SETSS = 1'b0;
    bits = 8'h00; prev = SCK; done_cnt = 0; first_done = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) begin
        START = 1'b1; TXD = 8'h22; SETSS = 1'b1; SSV = 2'b00;
      end
      tick();
      START = 1'b0; SETSS = 1'b0;
      if (SCK && !prev) bits = {bits[6:0], MOSI};
      prev = SCK;
      if (DONE) begin
        done_cnt++;
        if (first_done == 0) first_done = i;
      end
    end
    check("busy done_count", 32'(done_cnt), 32'd1);
    check("busy done_latency", 32'(first_done), 32'd16);
    check("busy mosi_bits", 32'(bits), 32'h11);
    check("busy nss_unchanged", 32'(nSS), 32'd2);
    check("busy rxd", 32'(RXD), 32'h11);

    // START on the DONE cycle: next byte begins at the following edge.
    START = 1'b1; TXD = 8'hC3;
    tick();
    START = 1'b0;
    check("b2b busy", 32'(BUSY), 32'd1);
    check("b2b mosi", 32'(MOSI), 32'd1);
    bits = 8'h00; prev = SCK; done_cnt = 0; first_done = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (SCK && !prev) bits = {bits[6:0], MOSI};
      prev = SCK;
      if (DONE) begin
        done_cnt++;
        if (first_done == 0) first_done = i;
      end
    end
    check("b2b done_count", 32'(done_cnt), 32'd1);
    check("b2b done_latency", 32'(first_done), 32'd16);
    check("b2b mosi_bits", 32'(bits), 32'hC3);
    check("b2b rxd", 32'(RXD), 32'hC3);

    // Abort after the third SCK rise.
    START = 1'b1; TXD = 8'h96; SETSS = 1'b1; SSV = 2'b10;
    tick();
    START = 1'b0; SETSS = 1'b0;
    rises = 0; prev = SCK;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (SCK && !prev) rises++;
      prev = SCK;
      if (rises == 3) break;
    end
    check("abort rises_seen", 32'(rises), 32'd3);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    check("abort sck", 32'(SCK), 32'd0);
    check("abort nss", 32'(nSS), 32'd3);
    check("abort busy", 32'(BUSY), 32'd0);
    check("abort done", 32'(DONE), 32'd0);
    check("abort rxd", 32'(RXD), 32'd0);
    check("abort mosi", 32'(MOSI), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (DONE) done_cnt++;
    end
    check("abort no_done", 32'(done_cnt), 32'd0);
    xfer("after_abort", 8'h5A, 2'b10, 1'b1, 3'b000, 8'h5A);

`ifdef SPI_CLKDIV_EN
    dval = 3;
    xfer("div3", 8'h3C, 2'b01, 1'b0, 3'b010, 8'hFF);
    dval = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
